// File: rtl/ir_fetch_unit_if.sv
// Fetch-unit bus: control-side request/abort, instruction-memory read port and IR result.
// mem_ready is only present when MEM_WAIT_EN is defined.
interface ir_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem_data;
`ifdef MEM_WAIT_EN
    logic              mem_ready;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              pc_inc;
    logic [15:0]       ir_out;
    logic              busy;
    logic              done;

    modport master (
        output start, flush, addr, mem_data,
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        input  mem_addr, mem_read, pc_inc, ir_out, busy, done
    );

    modport slave (
        input  start, flush, addr, mem_data,
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        output mem_addr, mem_read, pc_inc, ir_out, busy, done
    );
endinterface

// File: rtl/ir_fetch_unit.sv
// Two-byte little-endian instruction fetch into a 16-bit IR, one PC increment per byte.
// Optional MEM_WAIT_EN: memory handshakes each byte with mem_ready instead of fixed timing.
module ir_fetch_unit #(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input logic            clk,
    input logic            rst,
    ir_fetch_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LO_RD, HI_RD, HI_CAP, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        lo_byte;
    logic [15:0]       ir_r;
    logic              rd_r;
    logic              busy_r;
    logic              done_r;
    logic              mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // Flush must kill the read strobe and PC increment in the very cycle it is seen.
    assign bus.mem_read = rd_r & ~bus.flush;
    assign bus.pc_inc   = rd_r & ~bus.flush & mem_ok;
    assign bus.mem_addr = addr_r;
    assign bus.ir_out   = ir_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            addr_r  <= '0;
            lo_byte <= 8'h00;
            ir_r    <= IR_RESET;
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            rd_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            base   <= bus.addr;
                            addr_r <= bus.addr;
                            rd_r   <= 1'b1;
                            busy_r <= 1'b1;
                            state  <= LO_RD;
                        end else begin
                            state <= IDLE;
                        end
                    end
`ifdef MEM_WAIT_EN
                    LO_RD: begin
                        rd_r   <= 1'b1;
                        busy_r <= 1'b1;
                        if (bus.mem_ready) begin
                            lo_byte <= bus.mem_data;
                            addr_r  <= base + ADDR_W'(1);
                            state   <= HI_RD;
                        end
                    end
                    HI_RD: begin
                        if (bus.mem_ready) begin
                            ir_r   <= {bus.mem_data, lo_byte};
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            rd_r   <= 1'b1;
                            busy_r <= 1'b1;
                        end
                    end
`else
                    LO_RD: begin
                        rd_r   <= 1'b1;
                        busy_r <= 1'b1;
                        addr_r <= base + ADDR_W'(1);
                        state  <= HI_RD;
                    end
                    // Synchronous memory: the low byte arrives while the high byte is requested.
                    HI_RD: begin
                        lo_byte <= bus.mem_data;
                        busy_r  <= 1'b1;
                        state   <= HI_CAP;
                    end
                    HI_CAP: begin
                        ir_r   <= {bus.mem_data, lo_byte};
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ir_fetch_unit.sv
// Scoreboard bench for ir_fetch_unit: stimulus queues expected addresses/IR words,
// a negedge monitor pops and compares them whenever pc_inc or done is presented.
module tb_ir_fetch_unit;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    ir_fetch_unit #(.ADDR_W(ADDR_W), .IR_RESET(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr [$];
    logic [15:0] exp_ir [$];
    logic [15:0] model_ir = 16'h0000;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef MEM_WAIT_EN
    always @(posedge clk) begin
        #1;
        bus.mem_ready = ($urandom_range(0, 3) == 0);
    end
    always @* bus.mem_data = mem[bus.mem_addr];
`else
    always @(posedge clk) if (bus.mem_read) bus.mem_data <= mem[bus.mem_addr];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with empty scoreboard (t=%0t)", name, $time);
    endtask

    // Monitor: pops one expected byte address per pc_inc and one IR word per done.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst === 1'b0) begin
            if (bus.pc_inc) begin
                if (exp_addr.size() == 0) unexpected("pc_inc_unexpected");
                else begin
                    e = exp_addr.pop_front();
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e));
                end
                chk("mem_read_with_pc_inc", 32'(bus.mem_read), 32'd1);
            end
            if (bus.done) begin
                if (exp_ir.size() == 0) unexpected("done_unexpected");
                else begin
                    e = exp_ir.pop_front();
                    chk("ir_out", 32'(bus.ir_out), 32'(e));
                    model_ir = e;
                end
                chk("busy_in_done", 32'(bus.busy), 32'd0);
            end else begin
                chk("ir_hold", 32'(bus.ir_out), 32'(model_ir));
            end
        end
    end

    // Reference: a fetch of address a consumes a then a+1 (16-bit wrap), IR = {mem[a+1], mem[a]}.
    task automatic expect_fetch(input logic [15:0] a, input int n_bytes, input bit with_ir);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (n_bytes > 0) exp_addr.push_back(a);
        if (n_bytes > 1) exp_addr.push_back(a1);
        if (with_ir) exp_ir.push_back({mem[a1], mem[a]});
    endtask

    task automatic wait_done(output int cyc, input bit hold_start);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold_start) begin
                bus.start = bus.busy && ($urandom_range(0, 3) == 0);
                bus.addr  = 16'($urandom);
            end
        end while (!bus.done && cyc < 200);
        if (!bus.done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required done=1", bus.done, cyc);
        end
    endtask

    task automatic do_fetch(input logic [15:0] a);
        int cyc;
        expect_fetch(a, 2, 1'b1);
        @(posedge clk);
        #1;
        bus.addr  = a;
        bus.start = 1'b1;
        wait_done(cyc, 1'b0);
`ifndef MEM_WAIT_EN
        chk("latency", 32'(cyc), 32'd4);
`endif
    endtask

    initial begin
        int          cyc;
        logic [15:0] a;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.addr  = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;
        mem[16'h0042] = 8'h78;
        mem[16'h0043] = 8'h56;
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;

        #1;
        chk("rst_ir_out",   32'(bus.ir_out),   32'h0000);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_pc_inc",   32'(bus.pc_inc),   32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;

        do_fetch(16'h0040);
        do_fetch(16'hFFFF);

`ifndef MEM_WAIT_EN
        // Back-to-back with start held; finish with flush+start together in DONE.
        expect_fetch(16'h0040, 2, 1'b1);
        expect_fetch(16'h0042, 2, 1'b1);
        @(posedge clk);
        #1;
        bus.addr  = 16'h0040;
        bus.start = 1'b1;
        wait_done(cyc, 1'b1);
        chk("b2b_first_latency", 32'(cyc), 32'd4);
        bus.addr = 16'h0042;
        wait_done(cyc, 1'b1);
        chk("b2b_second_latency", 32'(cyc), 32'd4);
        bus.flush = 1'b1;
        #1;
        chk("done_under_flush", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_beats_start", 32'(bus.busy), 32'd0);

        // Flush in HI_RD after IR=1234.
        do_fetch(16'h0040);
        expect_fetch(16'h0100, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.addr  = 16'h0100;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        chk("flush_pc_inc",   32'(bus.pc_inc),   32'd0);
        chk("flush_mem_read", 32'(bus.mem_read), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("busy_after_flush", 32'(bus.busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("ir_after_flush", 32'(bus.ir_out), 32'h1234);

        // Asynchronous reset while in HI_CAP, between clock edges.
        expect_fetch(16'h0200, 2, 1'b0);
        @(posedge clk);
        #1;
        bus.addr  = 16'h0200;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_ir_out",   32'(bus.ir_out),   32'h0000);
        chk("midreset_busy",     32'(bus.busy),     32'd0);
        chk("midreset_mem_read", 32'(bus.mem_read), 32'd0);
        chk("midreset_done",     32'(bus.done),     32'd0);
        model_ir = 16'h0000;
        @(negedge clk);
        #2;
        rst = 1'b0;
        do_fetch(16'h0042);
`endif

        for (int n = 0; n < 30; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_fetch(a);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        chk("ir_queue_empty",   32'(exp_ir.size()),   32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Downstream consumer of the address register file's OutD port.
- Takes the fetch address (normally PC), performs two byte reads from the byte-wide instruction memory (low byte first, little-endian) and assembles a 16-bit instruction word for the instruction register.
- Emits one PC-increment pulse per byte read, which the control unit turns into an increment FunSel on the address register file.
- Ends the fetch with a one-cycle Done strobe.

Parameters:
- ADDR_W, 16, width of the fetch address and MemAddr.
- IR_RESET, 16'h0000, reset and initial value of IROut.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  fetch request; sampled only in IDLE or DONE.
- Flush  input  1  synchronous abort of an in-flight fetch.
- Addr  input  ADDR_W  fetch base address (from OutD); sampled on the edge that accepts Start.
- MemData  input  8  read data from instruction memory.
- MemReady  input  1  memory data-valid; present only when MEM_WAIT_EN is defined.
- MemAddr  output  ADDR_W  byte address to instruction memory.
- MemRead  output  1  memory read strobe.
- PCInc  output  1  one-cycle pulse per byte consumed.
- IROut  output  16  assembled instruction {hi byte, lo byte}.
- Busy  output  1  high in every state except IDLE and DONE.
- Done  output  1  one-cycle strobe; IROut is new in the same cycle.

Behaviour:
- Reset (async, any state):
  - state=IDLE, IROut=IR_RESET, low-byte staging register=0, base register=0.
  - MemRead=0, PCInc=0, Done=0, Busy=0, MemAddr=0.
- States: IDLE, LO_RD, HI_RD, HI_CAP, DONE.
- IDLE / DONE:
  - Start=1 latches base=Addr; next state is LO_RD.
  - Otherwise DONE goes to IDLE and IDLE stays in IDLE.
  - Done=1 only in DONE.
- LO_RD: MemRead=1, MemAddr=base, PCInc=1; next state HI_RD.
- HI_RD:
  - MemRead=1, MemAddr=base+1 (modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000), PCInc=1.
  - On the edge leaving this state, staging register <= MemData (low byte).
  - Next state HI_CAP.
- HI_CAP:
  - MemRead=0, PCInc=0.
  - On the edge leaving this state, IROut <= {MemData, staging}.
  - Next state DONE.
- Memory timing: synchronous read, data valid in the cycle after MemRead.
- Latency: Start accepted at edge E0 gives Done=1 in the cycle after edge E3. A back-to-back Start during DONE yields a fetch every 4 cycles.
- IROut is never partially updated; it changes only on the HI_CAP→DONE edge and holds otherwise.
- Outside LO_RD and HI_RD: MemAddr holds its last value and MemRead=0.
- Start while Busy is ignored; no queuing.
- Flush=1 in any Busy state:
  - Next state IDLE; PCInc and MemRead forced to 0 that cycle.
  - IROut and staging register unchanged; no Done.
  - Bytes already counted by earlier PCInc pulses are not retracted.
- Flush and Start in the same cycle in IDLE/DONE: Flush wins, Start is dropped, next state IDLE. In DONE, Done is still 1 that cycle.
- Reset mid-fetch: immediate return to IDLE; no further PCInc; IROut=IR_RESET.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - MemReady port exists and the fixed pipeline is replaced.
  - LO_RD holds MemRead=1 and MemAddr=base until MemReady=1. In that cycle: staging <= MemData, PCInc=1, next state HI_RD.
  - HI_RD holds MemAddr=base+1 until MemReady=1. In that cycle: IROut <= {MemData, staging}, PCInc=1, next state DONE.
  - HI_CAP is unused. Minimum latency: Done in the cycle after edge E2.
  - PCInc never asserts in a wait cycle. Flush during a wait aborts as above.
- Undefined: no MemReady port; fixed timing as specified above.

Test Plan:
- Basic fetch: memory[16'h0040]=8'h34, [16'h0041]=8'h12; Start with Addr=16'h0040 → MemAddr sequence 0040, 0041; exactly 2 PCInc pulses; Done one cycle 4 cycles after the Start edge; IROut=16'h1234.
- Wrap-around: Addr=16'hFFFF, [FFFF]=8'hCD, [0000]=8'hAB → second MemAddr=16'h0000; IROut=16'hABCD.
- Back-to-back: Start held high across two fetches (0040, then 0042 holding 16'h5678) → Done at cycles 4 and 8; IROut 1234 then 5678; Start during HI_RD ignored.
- Flush in HI_RD after a prior IROut=16'h1234 → no Done; IROut stays 16'h1234; exactly 1 PCInc observed; Busy=0 next cycle.
- Async reset asserted mid-HI_CAP, between clock edges → IROut=16'h0000, Busy=0, MemRead=0 immediately; Start after release fetches normally.
- MEM_WAIT_EN: MemReady low for 3 cycles on each byte → MemAddr stable during waits; PCInc only in the MemReady cycles; IROut=16'h1234; Done in the cycle after the second MemReady.
